booth_mul_seq: RTL and testbench
================================

Name: booth_mul_seq

Overview:
- Parametrised, sequential, signed radix-4 Booth multiplier.
- Retires one 2-bit Booth digit per clock, so a WIDTH-by-WIDTH multiply takes WIDTH/2 iterations.
- Successor to the combinational gate primitives: those fixed-width blocks become a clocked, width-generic datapath with start/done/clear control.
- Sits between the operand registers and the result bus of the multiplier top level.

Parameters:
- WIDTH, 32, operand width in bits. Must be even and at least 4; elaboration error otherwise.
- CNT_W, $clog2(WIDTH/2)+1, iteration counter width. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- op_start  input  1  start request; sampled only in INIT or DONE
- op_clear  input  1  synchronous abort/clear; valid in any state
- multiplicand  input  WIDTH  signed operand M; captured on accepted start
- multiplier  input  WIDTH  signed operand Q; captured on accepted start
- op_done  output  1  registered; high while result is valid
- result  output  2*WIDTH  registered signed product

Behaviour:
- Reset (async, any state): state=INIT, A=0, Q=0, q_m1=0, M=0, count=0, op_done=0, result=0.
- Datapath:
  - A is a WIDTH+2-bit accumulator; M is sign-extended to WIDTH+2.
  - Recode {Q[1],Q[0],q_m1}: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - -M and -2M are formed as ~x+1 at WIDTH+2 bits.
  - Per iteration: A' = A + pp, then {A',Q,q_m1} is shifted arithmetically right by 2. The sign bit of A' is replicated.
  - Sums wrap modulo 2^(WIDTH+2). WIDTH+2 bits are sufficient, so no overflow is possible.
- FSM states: INIT, EXEC, DONE.
  - INIT: idle. On op_start=1 and op_clear=0: load M, Q; set A=0, q_m1=0, count=0; go to EXEC.
  - EXEC: one iteration per cycle and count increments. When count reaches WIDTH/2 (after the last iteration), the next edge goes to DONE, captures result={A[WIDTH-1:0],Q} and sets op_done=1.
  - DONE: result and op_done are held. op_start (with op_clear=0) restarts directly: op_done falls and the state goes to EXEC on that edge, with result held until overwritten.
- Latency: op_done rises WIDTH/2+1 edges after the edge that accepts op_start (17 for WIDTH=32). The next start can be accepted in the first DONE cycle.
- op_clear, any state: go to INIT and zero A, Q, q_m1, count, op_done and result. op_clear beats a simultaneous op_start.
- op_start during EXEC is ignored. Operand changes during EXEC have no effect.
- Input values are don't-care except in the start cycle.
- Boundary cases:
  - Most-negative operands must produce exact 2*WIDTH-bit results: (-2^(W-1))^2 = 2^(2W-2).
  - Zero operands complete in full latency; there is no early termination.
- Reset asserted mid-EXEC aborts immediately. After deassertion the block is idle in INIT.

Decomposition:
- Package booth_pkg: state enum (INIT, EXEC, DONE) and a booth_digit_t enum (ZERO, P1, P2, N1, N2).
- Sub-module booth_r4_encoder, combinational:
  - inputs: 3-bit group and WIDTH+2-bit M
  - output: WIDTH+2-bit partial product pp
  - parameterised by WIDTH
- The FSM, counter and shift register stay in booth_mul_seq.

Test Plan:
- WIDTH=32, M=0x00000007, Q=0xFFFFFFFD, start -> op_done high exactly 17 edges later, result=0xFFFFFFFFFFFFFFEB; held for 5 idle cycles.
- WIDTH=32, M=0x80000000, Q=0x80000000 -> 0x4000000000000000. Then a back-to-back start from DONE with M=0x80000000, Q=0x7FFFFFFF -> 0xC000000080000000.
- WIDTH=8, M=0x80, Q=0x80 -> 0x4000 after 5 edges. M=0x00, Q=0x5A -> 0x0000 after full latency.
- WIDTH=32: start, then op_start re-pulsed with new operands at iteration 3 -> ignored, original product returned. Separately, op_clear at iteration 8 -> INIT, op_done=0, result=0; a new start then gives the correct product.
- Async reset asserted mid-EXEC between clock edges -> all outputs 0 immediately. A simultaneous op_start+op_clear in INIT -> remains in INIT.
- Random signed sweep, 10k vectors, WIDTH in {4,8,16,32} -> result equals the sign-extended reference product every time.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier.
// Holds the controller states, the Booth digit set and the digit recoder.
package booth_pkg;

   typedef enum logic [1:0] {
      INIT,
      EXEC,
      DONE
   } state_t;

   typedef enum logic [2:0] {
      ZERO,
      P1,
      P2,
      N1,
      N2
   } booth_digit_t;

   // Maps {q[1], q[0], q_m1} to the signed digit this pair contributes.
   function automatic booth_digit_t booth_recode(input logic [2:0] group);
      booth_digit_t digit;
      case (group)
         3'b001, 3'b010: digit = P1;
         3'b011:         digit = P2;
         3'b100:         digit = N2;
         3'b101, 3'b110: digit = N1;
         default:        digit = ZERO;
      endcase
      return digit;
   endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth partial-product generator.
// Produces 0, +M, +2M, -M or -2M at WIDTH+2 bits from one 3-bit group.
module booth_r4_encoder #(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       group,
   input  logic [WIDTH+1:0] m,
   output logic [WIDTH+1:0] pp
);
   import booth_pkg::*;

   localparam logic [WIDTH+1:0] ONE = {{(WIDTH+1){1'b0}}, 1'b1};

   booth_digit_t     digit;
   logic [WIDTH+1:0] m2;

   assign digit = booth_recode(group);
   assign m2    = m << 1;

   always_comb begin
      pp = '0;
      case (digit)
         P1:      pp = m;
         P2:      pp = m2;
         N1:      pp = ~m + ONE;
         N2:      pp = ~m2 + ONE;
         default: pp = '0;
      endcase
   end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed radix-4 Booth multiplier: one Booth digit per clock,
// WIDTH/2 iterations per product, with start/done/clear control.
module booth_mul_seq
   import booth_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH / 2) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               op_start,
   input  logic               op_clear,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               op_done,
   output logic [2*WIDTH-1:0] result
);

   localparam logic [CNT_W-1:0] HALF = CNT_W'(WIDTH / 2);

   if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("booth_mul_seq: WIDTH must be even and at least 4");
   end

   state_t             state, state_nx;
   logic [WIDTH+1:0]   a, m_ext, pp, a_sum;
   logic [WIDTH-1:0]   q;
   logic               q_m1;
   logic [CNT_W-1:0]   count;
   logic               load, step, finish;
   logic [2*WIDTH+2:0] shift_in, shift_out;

   booth_r4_encoder #(.WIDTH(WIDTH)) u_enc (
      .group ({q[1:0], q_m1}),
      .m     (m_ext),
      .pp    (pp)
   );

   assign a_sum     = a + pp;
   assign shift_in  = {a_sum, q, q_m1};
   assign shift_out = {{2{a_sum[WIDTH+1]}}, shift_in[2*WIDTH+2:2]};

   // Handshake: op_start is honoured only in INIT or DONE (op_clear low);
   // op_done stays high with result stable until the next accepted start or a clear.
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      step     = 1'b0;
      finish   = 1'b0;
      if (op_clear) begin
         state_nx = INIT;
      end else begin
         case (state)
            INIT, DONE: begin
               if (op_start) begin
                  state_nx = EXEC;
                  load     = 1'b1;
               end
            end
            EXEC: begin
               if (count == HALF) begin
                  state_nx = DONE;
                  finish   = 1'b1;
               end else begin
                  step = 1'b1;
               end
            end
            default: state_nx = INIT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= INIT;
         a       <= '0;
         q       <= '0;
         q_m1    <= 1'b0;
         m_ext   <= '0;
         count   <= '0;
         op_done <= 1'b0;
         result  <= '0;
      end else begin
         state <= state_nx;
         if (op_clear) begin
            a       <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            op_done <= 1'b0;
            result  <= '0;
         end else begin
            if (load) begin
               m_ext   <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
               q       <= multiplier;
               a       <= '0;
               q_m1    <= 1'b0;
               count   <= '0;
               op_done <= 1'b0;
            end
            if (step) begin
               a     <= shift_out[2*WIDTH+2:WIDTH+1];
               q     <= shift_out[WIDTH:1];
               q_m1  <= shift_out[0];
               count <= count + CNT_W'(1);
            end
            if (finish) begin
               // After WIDTH/2 shifts the product sits in the low half of A and all of Q.
               result  <= {a[WIDTH-1:0], q};
               op_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: four instances (WIDTH 4/8/16/32) checked against
// a plain signed-multiplication reference, with directed and random stimulus.
module tb_booth_mul_seq;

   logic        clk;
   logic        rst;
   logic        st [4];
   logic        cl [4];
   logic [31:0] mc [4];
   logic [31:0] mq [4];
   logic        dn [4];
   logic [63:0] rs [4];

   int errors = 0;
   int checks = 0;

   for (genvar i = 0; i < 4; i++) begin : g_dut
      localparam int W = 4 << i;
      logic [2*W-1:0] r;
      logic           d;
      booth_mul_seq #(.WIDTH(W)) u_dut (
         .clk          (clk),
         .reset        (rst),
         .op_start     (st[i]),
         .op_clear     (cl[i]),
         .multiplicand (mc[i][W-1:0]),
         .multiplier   (mq[i][W-1:0]),
         .op_done      (d),
         .result       (r)
      );
      assign dn[i] = d;
      assign rs[i] = 64'(r);
   end

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   function automatic int width_of(input int idx);
      return 4 << idx;
   endfunction

   // Reference: exact signed product of the two w-bit operands, kept to 2w bits.
   function automatic logic [63:0] ref_prod(input int w, input logic [31:0] m, input logic [31:0] q);
      longint sm, sq, p;
      logic [31:0] mask;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      sm = longint'(m & mask);
      sq = longint'(q & mask);
      if (m[w-1]) sm = sm - (longint'(1) << w);
      if (q[w-1]) sq = sq - (longint'(1) << w);
      p = sm * sq;
      if (w == 32) return 64'(p);
      return 64'(p) & ((64'h1 << (2 * w)) - 64'h1);
   endfunction

   // Caller is at a negedge. Optionally re-pulses op_start with junk operands
   // 'poke' edges after acceptance. Returns edges from accept to op_done.
   task automatic run_op(input int idx, input logic [31:0] m, input logic [31:0] q,
                         input int poke, output int lat, output logic [63:0] r);
      mc[idx] = m;
      mq[idx] = q;
      st[idx] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      st[idx] = 1'b0;
      mc[idx] = $urandom;
      mq[idx] = $urandom;
      lat = 0;
      while (!dn[idx] && lat < 100) begin
         if (lat == poke) begin
            st[idx] = 1'b1;
            mc[idx] = $urandom;
            mq[idx] = $urandom;
         end else begin
            st[idx] = 1'b0;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      st[idx] = 1'b0;
      r = rs[idx];
   endtask

   task automatic op_and_check(input string tag, input int idx, input logic [31:0] m,
                               input logic [31:0] q, input logic [63:0] exp, input int poke);
      int          lat;
      logic [63:0] r;
      run_op(idx, m, q, poke, lat, r);
      check({tag, "_lat"}, 64'(lat), 64'(width_of(idx) / 2 + 1));
      check({tag, "_res"}, r, exp);
   endtask

   function automatic logic [31:0] rand_operand(input int w);
      logic [31:0] v;
      v = $urandom;
      if ($urandom_range(0, 7) == 0) begin
         case ($urandom_range(0, 3))
            0:       v = 32'h0;
            1:       v = 32'h1 << (w - 1);
            2:       v = (32'h1 << (w - 1)) - 32'h1;
            default: v = 32'hFFFF_FFFF;
         endcase
      end
      return v;
   endfunction

   task automatic sweep(input int idx, input int n);
      logic [31:0] m, q;
      for (int k = 0; k < n; k++) begin
         m = rand_operand(width_of(idx));
         q = rand_operand(width_of(idx));
         op_and_check("sweep", idx, m, q, ref_prod(width_of(idx), m, q), -1);
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         st[i] = 1'b0;
         cl[i] = 1'b0;
         mc[i] = '0;
         mq[i] = '0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check("reset_done", 64'(dn[i]), 64'h0);
         check("reset_res", rs[i], 64'h0);
      end
      rst = 1'b0;
      @(negedge clk);

      // 7 * -3 at 32 bits, then hold for 5 idle cycles
      op_and_check("m7xn3", 3, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, -1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("hold_done", 64'(dn[3]), 64'h1);
         check("hold_res", rs[3], 64'hFFFF_FFFF_FFFF_FFEB);
      end

      // most-negative squared, then back-to-back start from the first DONE cycle
      op_and_check("minsq32", 3, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1);
      op_and_check("b2b32", 3, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, -1);

      op_and_check("minsq8", 1, 32'h80, 32'h80, 64'h4000, -1);
      op_and_check("zero8", 1, 32'h00, 32'h5A, 64'h0000, -1);

      // op_start re-pulsed at iteration 3 must be ignored
      op_and_check("restart_ign", 3, 32'h1234_5678, 32'hFEDC_BA98,
                   ref_prod(32, 32'h1234_5678, 32'hFEDC_BA98), 3);

      // op_clear at iteration 8
      mc[3] = 32'h0BAD_F00D;
      mq[3] = 32'h7654_3210;
      st[3] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      st[3] = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      cl[3] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cl[3] = 1'b0;
      check("clear_done", 64'(dn[3]), 64'h0);
      check("clear_res", rs[3], 64'h0);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("clear_idle_done", 64'(dn[3]), 64'h0);
      op_and_check("after_clear", 3, 32'hFFFF_FF00, 32'h0000_0321,
                   ref_prod(32, 32'hFFFF_FF00, 32'h0000_0321), -1);

      // async reset between edges during EXEC
      mc[3] = 32'h0000_1111;
      mq[3] = 32'h0000_2222;
      st[3] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      st[3] = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_done", 64'(dn[3]), 64'h0);
      check("async_rst_res", rs[3], 64'h0);
      @(negedge clk);
      rst = 1'b0;

      // simultaneous start + clear in INIT stays idle
      mc[3] = 32'h0000_0005;
      mq[3] = 32'h0000_0006;
      st[3] = 1'b1;
      cl[3] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      st[3] = 1'b0;
      cl[3] = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("start_clear_done", 64'(dn[3]), 64'h0);
      check("start_clear_res", rs[3], 64'h0);

      // random signed sweep, 10k vectors across the four widths
      fork
         sweep(0, 2500);
         sweep(1, 2500);
         sweep(2, 2500);
         sweep(3, 2500);
      join

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
